dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_if.sv | 32 +++
 rtl/dm_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - two-port request bus plus memory-side signals for dm_arbiter
interface dm_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          req0,   req1;
    logic          we0,    we1;
    logic [AW-1:0] addr0,  addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0,   gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_dout;
    logic          busy;
    logic [CW-1:0] cnt0,   cnt1;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_din, mem_wen, mem_ren, busy, cnt0, cnt1
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_din, mem_wen, mem_ren, busy, cnt0, cnt1
    );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin two-port arbiter for a single-port synchronous data memory
module dm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          pick;

    // All outputs decode from state_q only, so the async reset clears them without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign pick = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        bus.gnt0     = 1'b0;
        bus.gnt1     = 1'b0;
        bus.rvalid0  = 1'b0;
        bus.rvalid1  = 1'b0;
        bus.rdata0   = '0;
        bus.rdata1   = '0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_wen  = 1'b0;
        bus.mem_ren  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d      = ACCESS;
                    win_d        = pick;
                    last_grant_d = pick;
                    we_d         = pick ? bus.we1    : bus.we0;
                    addr_d       = pick ? bus.addr1  : bus.addr0;
                    wdata_d      = pick ? bus.wdata1 : bus.wdata0;
                    if (!pick && cnt0_q != '1) cnt0_d = cnt0_q + CW'(1);
                    if (pick && cnt1_q != '1)  cnt1_d = cnt1_q + CW'(1);
                end
            end
            ACCESS: begin
                bus.mem_addr = addr_q;
                bus.mem_din  = we_q ? wdata_q : '0;
                bus.mem_wen  = we_q;
                bus.mem_ren  = ~we_q;
                bus.gnt0     = ~win_q;
                bus.gnt1     = win_q;
                state_d      = we_q ? IDLE : RESP;
            end
            RESP: begin
                bus.rvalid0 = ~win_q;
                bus.rvalid1 = win_q;
                bus.rdata0  = win_q ? '0 : bus.mem_dout;
                bus.rdata1  = win_q ? bus.mem_dout : '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
endmodule
